// File: rtl/syn_inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   IM_ADDR_BIT       : width of an instruction-memory word address
//   IFQ_DEPTH_DEFAULT : default number of queue entries
//   ifq_state_e       : fetch FSM encoding (IDLE / REQ / DROP)
//   addr_inc()        : word address + 1, wrapping modulo 2^IM_ADDR_BIT
package syn_inst_fetch_queue_pkg;

    localparam int IM_ADDR_BIT       = 10;
    localparam int IFQ_DEPTH_DEFAULT = 4;

    typedef logic [IM_ADDR_BIT-1:0] im_addr_t;

    typedef enum logic [1:0] {
        IFQ_ST_IDLE = 2'd0,  // queue full, no request on the bus
        IFQ_ST_REQ  = 2'd1,  // request at fetch_pc on the bus
        IFQ_ST_DROP = 2'd2   // stale request held until its ack, data discarded
    } ifq_state_e;

    function automatic im_addr_t addr_inc(input im_addr_t a);
        return a + im_addr_t'(1);
    endfunction

endpackage

// File: rtl/syn_inst_fetch_queue_buffer.sv
// Circular instruction buffer: entries, read/write pointers and occupancy.
// Each entry holds the instruction and its word address + 1.
//   clk, rst_n            : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   push/push_inst/pc_4   : write one entry at the tail
//   pop                   : retire the head entry
//   flush                 : empty the buffer (overrides push and pop)
//   count / count_next    : current and next-cycle occupancy
//   head_inst / head_pc_4 : registered head entry
module syn_inst_fetch_queue_buffer
    import syn_inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_inst,
    input  im_addr_t    push_pc_4,
    output logic [3:0]  count,
    output logic [3:0]  count_next,
    output logic [31:0] head_inst,
    output im_addr_t    head_pc_4
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [31:0] inst_mem [DEPTH];
    im_addr_t    pc_mem   [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + 4'(push) - 4'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count_next;
        end
    end

    // NOTE: the entry array has no reset; occupancy and pointers alone decide
    // which entries are meaningful, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr]   <= push_pc_4;
        end
    end

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc_4 = pc_mem[rd_ptr];

endmodule

// File: rtl/syn_inst_fetch_queue.sv
// Instruction fetch queue: issues one outstanding instruction-memory request
// at a time, buffers returned instructions and presents them to IF/ID.
//   clk, rst_n          : clock; rst_n is a synchronous ACTIVE-HIGH reset
//   en                  : global enable, low freezes all state
//   redirect/_pc        : taken branch/jump; flush queue and refetch from _pc
//   im_req/im_addr      : memory request and word address
//   im_ack/im_inst      : memory completion and returned instruction
//   out_valid/out_ready : head handshake toward IF/ID
//   out_inst/out_pc_4   : head instruction and its word address + 1
//   count               : occupied entries
module syn_inst_fetch_queue
    import syn_inst_fetch_queue_pkg::*;
#(
    parameter int       DEPTH    = IFQ_DEPTH_DEFAULT,
    parameter im_addr_t RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect,
    input  im_addr_t    redirect_pc,
    output logic        im_req,
    output im_addr_t    im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output im_addr_t    out_pc_4,
    output logic [3:0]  count
);

    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    ifq_state_e state, state_next;
    im_addr_t   fetch_pc, fetch_pc_next;
    im_addr_t   drop_addr, drop_addr_next;
    logic [3:0] count_next;
    logic       ack, push, pop, flush;

    assign im_req    = en && (state == IFQ_ST_REQ || state == IFQ_ST_DROP);
    assign im_addr   = (state == IFQ_ST_DROP) ? drop_addr : fetch_pc;
    assign ack       = im_req && im_ack;
    assign out_valid = (count != 4'd0);

    // A redirect discards both the returning instruction and the head pop.
    assign flush = en && redirect;
    assign push  = ack && (state == IFQ_ST_REQ) && !redirect;
    assign pop   = en && out_valid && out_ready && !redirect;

    syn_inst_fetch_queue_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_inst  (im_inst),
        .push_pc_4  (addr_inc(fetch_pc)),
        .count      (count),
        .count_next (count_next),
        .head_inst  (out_inst),
        .head_pc_4  (out_pc_4)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_addr_next = drop_addr;
        if (redirect) fetch_pc_next = redirect_pc;

        unique case (state)
            IFQ_ST_IDLE: begin
                // Request again only once a slot will be free (credit rule).
                if (count_next < DEPTH_CNT) state_next = IFQ_ST_REQ;
            end
            IFQ_ST_REQ: begin
                if (redirect) begin
                    if (!ack) begin
                        // Keep the stale address on the bus until it completes.
                        drop_addr_next = fetch_pc;
                        state_next     = IFQ_ST_DROP;
                    end
                end else if (ack) begin
                    fetch_pc_next = addr_inc(fetch_pc);
                    state_next    = (count_next < DEPTH_CNT) ? IFQ_ST_REQ : IFQ_ST_IDLE;
                end
            end
            IFQ_ST_DROP: begin
                if (ack) state_next = IFQ_ST_REQ;
            end
            default: state_next = IFQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IFQ_ST_IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
        end else if (en) begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            drop_addr <= drop_addr_next;
        end
    end

endmodule

// File: tb/tb_syn_inst_fetch_queue.sv
module tb_syn_inst_fetch_queue;
    import syn_inst_fetch_queue_pkg::*;

    localparam int       DEPTH    = 4;
    localparam im_addr_t RESET_PC = '0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    im_addr_t    redirect_pc = '0;
    logic        im_req;
    im_addr_t    im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    im_addr_t    out_pc_4;
    logic [3:0]  count;

    syn_inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_inst     (im_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc_4    (out_pc_4),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue contents plus the one outstanding request.
    typedef struct {
        logic [31:0] inst;
        im_addr_t    pc4;
    } ent_t;

    ent_t     m_q[$];
    im_addr_t m_fetch_pc;
    bit       m_pending;   // a request is (or would be, if enabled) on the bus
    bit       m_doomed;    // that request's data will be thrown away
    im_addr_t m_req_addr;
    int       wait_cnt;    // cycles the current request has waited

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = RESET_PC;
        m_pending  = 1'b0;
        m_doomed   = 1'b0;
        m_req_addr = RESET_PC;
        wait_cnt   = 0;
    endtask

    task automatic model_edge(input bit e, input bit rd, input im_addr_t rpc,
                              input bit rdy, input bit ack_in, input logic [31:0] inst);
        bit   done;
        ent_t ent;
        if (!e) return;
        done = m_pending && ack_in;
        if (rd) begin
            m_q.delete();
            m_fetch_pc = rpc;
            if (!m_pending || done) begin
                m_pending  = 1'b1;
                m_doomed   = 1'b0;
                m_req_addr = rpc;
            end else begin
                m_doomed = 1'b1;
            end
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (done && !m_doomed) begin
                ent.inst   = inst;
                ent.pc4    = m_req_addr + im_addr_t'(1);
                m_q.push_back(ent);
                m_fetch_pc = ent.pc4;
            end
            if (done) begin
                m_pending  = m_doomed ? 1'b1 : (m_q.size() < DEPTH);
                m_doomed   = 1'b0;
                m_req_addr = m_fetch_pc;
            end else if (!m_pending) begin
                m_pending  = (m_q.size() < DEPTH);
                m_req_addr = m_fetch_pc;
            end
        end
    endtask

    task automatic check_outputs(input bit exp_req);
        check("im_req", 32'(im_req), 32'(exp_req));
        if (m_pending) check("im_addr", 32'(im_addr), 32'(m_req_addr));
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("count", 32'(count), 32'(m_q.size()));
        if (m_q.size() > 0) begin
            check("out_inst", out_inst, m_q[0].inst);
            check("out_pc_4", 32'(out_pc_4), 32'(m_q[0].pc4));
        end
    endtask

    // One clock cycle. lat < 0: random ack; lat >= 0: ack after lat wait cycles.
    // junk drives im_ack while no request is expected.
    task automatic cycle(input bit e, input bit rd, input im_addr_t rpc, input bit rdy,
                         input int lat, input bit junk, output bit hs);
        bit          exp_req;
        logic [31:0] inst;
        @(negedge clk);
        en          = e;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        inst        = $urandom;
        im_inst     = inst;
        exp_req     = e && m_pending;
        if (exp_req) im_ack = (lat < 0) ? 1'($urandom_range(0, 1)) : (wait_cnt >= lat);
        else         im_ack = junk;
        #1;
        check_outputs(exp_req);
        hs = exp_req && im_ack;
        @(posedge clk);
        model_edge(e, rd, rpc, rdy, im_ack, inst);
        if (hs || !m_pending) wait_cnt = 0;
        else if (exp_req)     wait_cnt++;
    endtask

    // Reset is asserted together with en and redirect to show its priority.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b1;
        en          = 1'b1;
        redirect    = 1'b1;
        redirect_pc = im_addr_t'($urandom);
        im_ack      = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk);
        #2;
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n    = 1'b0;
        en       = 1'b0;
        redirect = 1'b0;
        im_ack   = 1'b0;
        model_reset();
    endtask

    initial begin
        bit       hs;
        int       n;
        im_addr_t rpc;

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Zero-wait memory, consumer always ready: one instruction per cycle.
        for (int i = 0; i < 12; i++) cycle(1, 0, '0, 1, 0, 0, hs);
        #2;
        check("stream_count", 32'(count), 32'd1);

        // Redirect together with a pop and an ack.
        cycle(1, 1, im_addr_t'(10'h055), 1, 0, 0, hs);
        #2;
        check("redir_count", 32'(count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(im_addr), 32'h055);

        // Consumer stalled: fill to DEPTH, then one pop re-opens fetching.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, '0, 0, 0, 0, hs);
        #2;
        check("full_count", 32'(count), 32'd4);
        check("full_im_req", 32'(im_req), 32'd0);
        cycle(1, 0, '0, 1, 0, 0, hs);
        #2;
        check("refill_req", 32'(im_req), 32'd1);
        check("refill_addr", 32'(im_addr), 32'd4);
        cycle(1, 0, '0, 0, 0, 0, hs);

        // 3-cycle memory, redirect in the 2nd wait cycle of the first request.
        do_reset();
        n = 0;
        while (!(m_pending && wait_cnt == 1) && n < 10) begin
            cycle(1, 0, '0, 1, 3, 0, hs);
            n++;
        end
        cycle(1, 1, im_addr_t'(10'h100), 1, 3, 0, hs);
        #2;
        check("drop_hold_addr", 32'(im_addr), 32'd0);
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 10) begin
            cycle(1, 0, '0, 1, 3, 0, hs);
            n++;
        end
        check("drop_ack_seen", 32'(hs), 32'd1);
        #2;
        check("drop_new_addr", 32'(im_addr), 32'h100);
        check("drop_count", 32'(count), 32'd0);

        // Address wrap at the top of the space, then a 3-cycle freeze.
        do_reset();
        cycle(1, 1, im_addr_t'(10'h3FF), 1, 0, 0, hs);
        cycle(1, 0, '0, 1, 0, 0, hs);
        #2;
        check("wrap_pc_4", 32'(out_pc_4), 32'd0);
        check("wrap_addr", 32'(im_addr), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 1, im_addr_t'(10'h2AA), 1, 0, 1, hs);
        #2;
        check("freeze_count", 32'(count), 32'd1);
        check("freeze_addr", 32'(im_addr), 32'd0);
        cycle(1, 0, '0, 1, 0, 0, hs);

        // Randomized traffic, including a reset in the middle of a request.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            rpc = ($urandom_range(0, 3) == 0) ? im_addr_t'(10'h3FC + 10'($urandom_range(0, 3)))
                                              : im_addr_t'($urandom);
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, rpc,
                  1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), hs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
